// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
// Holds the FSM state encoding, the default phase timings and the write/read encodings.
package rtc_bus_pkg;

  localparam int DATA_W = 8;

  localparam int unsigned DEF_T_SU  = 2;
  localparam int unsigned DEF_T_PW  = 5;
  localparam int unsigned DEF_T_HD  = 2;
  localparam int unsigned DEF_T_GAP = 4;

  localparam logic WE_WRITE = 1'b1;
  localparam logic WE_READ  = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SU,
    S_A_PW,
    S_A_HD,
    S_GAP,
    S_D_SU,
    S_D_PW,
    S_D_HD,
    S_DONE
  } state_t;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that paces each timed bus state.
// A state loaded with N-1 sees the zero flag on its N-th cycle.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Two-port round-robin sequencer for the external RTC's multiplexed AD bus.
// Every output is registered from the next-state decode, so the pins line up with the state register.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU  = DEF_T_SU,
  parameter int unsigned T_PW  = DEF_T_PW,
  parameter int unsigned T_HD  = DEF_T_HD,
  parameter int unsigned T_GAP = DEF_T_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr
);

  localparam logic [7:0] SU_M1  = 8'(T_SU - 1);
  localparam logic [7:0] PW_M1  = 8'(T_PW - 1);
  localparam logic [7:0] HD_M1  = 8'(T_HD - 1);
  localparam logic [7:0] GAP_M1 = 8'(T_GAP - 1);

  state_t            r_state;
  state_t            w_nxt_state;
  logic              r_last_grant;
  logic              r_port;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_ad_out;
  logic              r_cs, r_rd, r_wr, r_ad, r_oe, r_ack0, r_ack1, r_busy;

  logic              w_grant;
  logic              w_gnt_port;
  logic              w_cur_port;
  logic              w_cur_we;
  logic [DATA_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;
  logic              w_zero;
  logic              w_load;
  logic [7:0]        w_load_val;
  logic              w_cs, w_rd, w_wr, w_ad, w_oe, w_ack0, w_ack1;
  logic [DATA_W-1:0] w_ad_out;

  function automatic logic [7:0] dur_m1(input state_t s);
    case (s)
      S_A_SU, S_D_SU: dur_m1 = SU_M1;
      S_A_PW, S_D_PW: dur_m1 = PW_M1;
      S_A_HD, S_D_HD: dur_m1 = HD_M1;
      S_GAP:          dur_m1 = GAP_M1;
      default:        dur_m1 = 8'd0;
    endcase
  endfunction

  rtc_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_grant     = 1'b0;
    w_gnt_port  = r_port;
    case (r_state)
      S_IDLE: begin
        // With both ports pending, the one not served last time wins.
        if (req0 && req1) begin
          w_grant    = 1'b1;
          w_gnt_port = ~r_last_grant;
        end else if (req0) begin
          w_grant    = 1'b1;
          w_gnt_port = 1'b0;
        end else if (req1) begin
          w_grant    = 1'b1;
          w_gnt_port = 1'b1;
        end
        if (w_grant) w_nxt_state = S_A_SU;
      end
      S_A_SU:  if (w_zero) w_nxt_state = S_A_PW;
      S_A_PW:  if (w_zero) w_nxt_state = S_A_HD;
      S_A_HD:  if (w_zero) w_nxt_state = S_GAP;
      S_GAP:   if (w_zero) w_nxt_state = S_D_SU;
      S_D_SU:  if (w_zero) w_nxt_state = S_D_PW;
      S_D_PW:  if (w_zero) w_nxt_state = S_D_HD;
      S_D_HD:  if (w_zero) w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign w_cur_port  = w_grant ? w_gnt_port : r_port;
  assign w_cur_we    = w_grant ? (w_gnt_port ? we1 : we0) : r_we;
  assign w_cur_addr  = w_grant ? (w_gnt_port ? addr1 : addr0) : r_addr;
  assign w_cur_wdata = w_grant ? (w_gnt_port ? wdata1 : wdata0) : r_wdata;

  assign w_load     = (w_nxt_state != r_state);
  assign w_load_val = dur_m1(w_nxt_state);

  always_comb begin
    w_cs     = 1'b1;
    w_rd     = 1'b1;
    w_wr     = 1'b1;
    w_ad     = 1'b1;
    w_oe     = 1'b0;
    w_ad_out = r_ad_out;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    case (w_nxt_state)
      S_A_SU, S_A_PW, S_A_HD: begin
        w_cs     = 1'b0;
        w_ad     = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = w_cur_addr;
        w_wr     = (w_nxt_state != S_A_PW);
      end
      S_D_SU, S_D_PW, S_D_HD: begin
        w_cs = 1'b0;
        w_oe = (w_cur_we == WE_WRITE);
        if (w_cur_we == WE_WRITE) w_ad_out = w_cur_wdata;
        if (w_nxt_state == S_D_PW) begin
          if (w_cur_we == WE_WRITE) w_wr = 1'b0;
          else                      w_rd = 1'b0;
        end
      end
      S_DONE: begin
        w_ack0 = ~w_cur_port;
        w_ack1 = w_cur_port;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= WE_READ;
      r_rdata      <= '0;
      r_ad_out     <= '0;
      r_cs         <= 1'b1;
      r_rd         <= 1'b1;
      r_wr         <= 1'b1;
      r_ad         <= 1'b1;
      r_oe         <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_ad_out <= w_ad_out;
      r_cs     <= w_cs;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_ad     <= w_ad;
      r_oe     <= w_oe;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_busy   <= (w_nxt_state != S_IDLE);
      if (w_grant) begin
        r_last_grant <= w_gnt_port;
        r_port       <= w_gnt_port;
        r_we         <= w_cur_we;
      end
      // Sample AD on the final strobe cycle, just before rd rises.
      if (r_state == S_D_PW && w_zero && r_we == WE_READ) r_rdata <= ad_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= w_cur_addr;
      r_wdata <= w_cur_wdata;
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata  = r_rdata;
  assign busy   = r_busy;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_oe;
  assign a_d    = r_ad;
  assign cs     = r_cs;
  assign rd     = r_rd;
  assign wr     = r_wr;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default-timing and all-ones-timing instances driven side by side,
// checked each cycle against a phase-offset model plus directed literal expectations.
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       req0_v [2];
  logic       we0_v  [2];
  logic [7:0] addr0_v [2];
  logic [7:0] wdata0_v [2];
  logic       req1_v [2];
  logic       we1_v  [2];
  logic [7:0] addr1_v [2];
  logic [7:0] wdata1_v [2];
  logic [7:0] ad_in_v [2];
  logic       ack0_v [2];
  logic       ack1_v [2];
  logic       busy_v [2];
  logic       ad_oe_v [2];
  logic       a_d_v [2];
  logic       cs_v [2];
  logic       rd_v [2];
  logic       wr_v [2];
  logic [7:0] rdata_v [2];
  logic [7:0] ad_out_v [2];

  int total = 0;
  int bad   = 0;

  initial forever #5 clk = ~clk;

  rtc_bus_sequencer dut0 (
    .clk(clk), .rst(rst),
    .req0(req0_v[0]), .we0(we0_v[0]), .addr0(addr0_v[0]), .wdata0(wdata0_v[0]), .ack0(ack0_v[0]),
    .req1(req1_v[0]), .we1(we1_v[0]), .addr1(addr1_v[0]), .wdata1(wdata1_v[0]), .ack1(ack1_v[0]),
    .rdata(rdata_v[0]), .busy(busy_v[0]), .ad_out(ad_out_v[0]), .ad_oe(ad_oe_v[0]),
    .ad_in(ad_in_v[0]), .a_d(a_d_v[0]), .cs(cs_v[0]), .rd(rd_v[0]), .wr(wr_v[0])
  );

  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0_v[1]), .we0(we0_v[1]), .addr0(addr0_v[1]), .wdata0(wdata0_v[1]), .ack0(ack0_v[1]),
    .req1(req1_v[1]), .we1(we1_v[1]), .addr1(addr1_v[1]), .wdata1(wdata1_v[1]), .ack1(ack1_v[1]),
    .rdata(rdata_v[1]), .busy(busy_v[1]), .ad_out(ad_out_v[1]), .ad_oe(ad_oe_v[1]),
    .ad_in(ad_in_v[1]), .a_d(a_d_v[1]), .cs(cs_v[1]), .rd(rd_v[1]), .wr(wr_v[1])
  );

  // Model: per instance, the transaction in flight and the cycle offset k since its grant.
  int         su_m  [2] = '{2, 1};
  int         pw_m  [2] = '{5, 1};
  int         hd_m  [2] = '{2, 1};
  int         gap_m [2] = '{4, 1};
  bit         busy_m [2];
  int         k_m [2];
  bit         port_m [2];
  bit         we_m [2];
  bit         last_m [2];
  logic [7:0] addr_m [2];
  logic [7:0] wdata_m [2];
  logic [7:0] rdata_m [2];

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d actual=%b required=%b t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    logic       e_cs, e_rd, e_wr, e_ad, e_oe, e_a0, e_a1, cap;
    logic [7:0] e_out;
    int         P, L, j, k;
    bit         strobe, g, r0, r1;
    if (!rst) begin
      busy_m[i]  = 1'b0;
      last_m[i]  = 1'b1;
      rdata_m[i] = 8'h00;
      k_m[i]     = 0;
      chk1("rst_cs", i, cs_v[i], 1'b1);
      chk1("rst_rd", i, rd_v[i], 1'b1);
      chk1("rst_wr", i, wr_v[i], 1'b1);
      chk1("rst_a_d", i, a_d_v[i], 1'b1);
      chk1("rst_oe", i, ad_oe_v[i], 1'b0);
      chk1("rst_ack0", i, ack0_v[i], 1'b0);
      chk1("rst_ack1", i, ack1_v[i], 1'b0);
      chk1("rst_busy", i, busy_v[i], 1'b0);
      chk8("rst_ad_out", i, ad_out_v[i], 8'h00);
      chk8("rst_rdata", i, rdata_v[i], 8'h00);
    end else begin
      e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_ad = 1'b1; e_oe = 1'b0;
      e_a0 = 1'b0; e_a1 = 1'b0; cap = 1'b0; e_out = 8'h00;
      P = su_m[i] + pw_m[i] + hd_m[i];
      L = 2 * P + gap_m[i] + 1;
      k = k_m[i];
      if (busy_m[i]) begin
        if (k <= P) begin
          j = k;
          strobe = (j > su_m[i]) && (j <= su_m[i] + pw_m[i]);
          e_cs = 1'b0; e_ad = 1'b0; e_oe = 1'b1; e_out = addr_m[i];
          e_wr = !strobe;
        end else if (k <= P + gap_m[i]) begin
          e_cs = 1'b1;
        end else if (k <= 2 * P + gap_m[i]) begin
          j = k - P - gap_m[i];
          strobe = (j > su_m[i]) && (j <= su_m[i] + pw_m[i]);
          e_cs = 1'b0; e_oe = we_m[i]; e_out = wdata_m[i];
          if (strobe && we_m[i])  e_wr = 1'b0;
          if (strobe && !we_m[i]) e_rd = 1'b0;
          cap = !we_m[i] && (j == su_m[i] + pw_m[i]);
        end else begin
          e_a0 = !port_m[i];
          e_a1 = port_m[i];
        end
      end
      chk1("cs", i, cs_v[i], e_cs);
      chk1("rd", i, rd_v[i], e_rd);
      chk1("wr", i, wr_v[i], e_wr);
      chk1("a_d", i, a_d_v[i], e_ad);
      chk1("ad_oe", i, ad_oe_v[i], e_oe);
      chk1("ack0", i, ack0_v[i], e_a0);
      chk1("ack1", i, ack1_v[i], e_a1);
      chk1("busy", i, busy_v[i], busy_m[i]);
      chk8("rdata", i, rdata_v[i], rdata_m[i]);
      if (e_oe) chk8("ad_out", i, ad_out_v[i], e_out);
      chk1("inv_rd_wr_excl", i, !(rd_v[i] == 1'b0 && wr_v[i] == 1'b0), 1'b1);
      chk1("inv_strobe_cs", i, !(cs_v[i] == 1'b1 && (rd_v[i] == 1'b0 || wr_v[i] == 1'b0)), 1'b1);
      chk1("inv_oe_rd", i, !(rd_v[i] == 1'b0 && ad_oe_v[i] == 1'b1), 1'b1);
      if (cap) rdata_m[i] = ad_in_v[i];
      if (busy_m[i]) begin
        if (k >= L) busy_m[i] = 1'b0;
        else        k_m[i] = k + 1;
      end else begin
        r0 = (req0_v[i] === 1'b1);
        r1 = (req1_v[i] === 1'b1);
        if (r0 || r1) begin
          g = (r0 && r1) ? !last_m[i] : r1;
          port_m[i]  = g;
          last_m[i]  = g;
          we_m[i]    = g ? we1_v[i] : we0_v[i];
          addr_m[i]  = g ? addr1_v[i] : addr0_v[i];
          wdata_m[i] = g ? wdata1_v[i] : wdata0_v[i];
          busy_m[i]  = 1'b1;
          k_m[i]     = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic step_to(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Runs one request and measures strobe widths; called at posedge+1.
  task automatic run_txn(input int i, input bit p, input bit we, input logic [7:0] a,
                         input logic [7:0] d, output int n, output int wa, output int wd,
                         output int rl, output logic [7:0] rdat);
    n = 0; wa = 0; wd = 0; rl = 0; rdat = 8'h00;
    if (!p) begin
      req0_v[i] = 1'b1; we0_v[i] = we; addr0_v[i] = a; wdata0_v[i] = d;
    end else begin
      req1_v[i] = 1'b1; we1_v[i] = we; addr1_v[i] = a; wdata1_v[i] = d;
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (!wr_v[i] && !a_d_v[i] && ad_oe_v[i] && ad_out_v[i] == a) wa++;
      if (!wr_v[i] && a_d_v[i] && ad_oe_v[i] && ad_out_v[i] == d) wd++;
      if (!rd_v[i] && !ad_oe_v[i]) rl++;
      if ((!p && ack0_v[i]) || (p && ack1_v[i])) begin
        rdat = rdata_v[i];
        break;
      end
    end
    req0_v[i] = 1'b0;
    req1_v[i] = 1'b0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      ad_in_v[i] = 8'($urandom);
      if (req0_v[i] && ack0_v[i]) begin
        if ($urandom_range(0, 3) != 0) req0_v[i] = 1'b0;
        else begin
          we0_v[i] = 1'($urandom); addr0_v[i] = 8'($urandom); wdata0_v[i] = 8'($urandom);
        end
      end else if (!req0_v[i] && $urandom_range(0, 5) == 0) begin
        req0_v[i] = 1'b1; we0_v[i] = 1'($urandom); addr0_v[i] = 8'($urandom); wdata0_v[i] = 8'($urandom);
      end
      if (req1_v[i] && ack1_v[i]) begin
        if ($urandom_range(0, 3) != 0) req1_v[i] = 1'b0;
        else begin
          we1_v[i] = 1'($urandom); addr1_v[i] = 8'($urandom); wdata1_v[i] = 8'($urandom);
        end
      end else if (!req1_v[i] && $urandom_range(0, 5) == 0) begin
        req1_v[i] = 1'b1; we1_v[i] = 1'($urandom); addr1_v[i] = 8'($urandom); wdata1_v[i] = 8'($urandom);
      end
    end
  endtask

  initial begin
    int n, wa, wd, rl, nacks;
    int ack_cyc [3];
    int ack_prt [3];
    logic [7:0] rdat;
    bit found;

    for (int i = 0; i < 2; i++) begin
      req0_v[i] = 1'b0; we0_v[i] = 1'b0; addr0_v[i] = 8'h00; wdata0_v[i] = 8'h00;
      req1_v[i] = 1'b0; we1_v[i] = 1'b0; addr1_v[i] = 8'h00; wdata1_v[i] = 8'h00;
      ad_in_v[i] = 8'h00;
    end
    for (int c = 0; c < 3; c++) begin ack_cyc[c] = -1; ack_prt[c] = -1; end

    // Contention from reset: both ports already requesting when reset lifts.
    req0_v[0] = 1'b1; we0_v[0] = 1'b1; addr0_v[0] = 8'h10; wdata0_v[0] = 8'hA0;
    req1_v[0] = 1'b1; we1_v[0] = 1'b1; addr1_v[0] = 8'h11; wdata1_v[0] = 8'hB1;
    step_to(3);
    chk1("reset_cs", 0, cs_v[0], 1'b1);
    chk1("reset_a_d", 0, a_d_v[0], 1'b1);
    chk1("reset_oe", 1, ad_oe_v[1], 1'b0);
    chk1("reset_busy", 0, busy_v[0], 1'b0);
    rst = 1'b1;
    n = 0; nacks = 0;
    for (int c = 0; c < 100 && nacks < 3; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (ack0_v[0] || ack1_v[0]) begin
        ack_cyc[nacks] = n;
        ack_prt[nacks] = ack1_v[0] ? 1 : 0;
        nacks++;
      end
    end
    req0_v[0] = 1'b0; req1_v[0] = 1'b0;
    chki("contention_acks", nacks, 3);
    chki("contention_cyc0", ack_cyc[0], 23);
    chki("contention_port0", ack_prt[0], 0);
    chki("contention_cyc1", ack_cyc[1], 47);
    chki("contention_port1", ack_prt[1], 1);
    chki("contention_cyc2", ack_cyc[2], 71);
    chki("contention_port2", ack_prt[2], 0);
    step_to(3);

    // Single write on port 0, default timing.
    run_txn(0, 1'b0, 1'b1, 8'h21, 8'h45, n, wa, wd, rl, rdat);
    chki("wr_latency", n, 23);
    chki("wr_addr_strobe", wa, 5);
    chki("wr_data_strobe", wd, 5);
    chki("wr_no_rd", rl, 0);
    chk8("wr_rdata_kept", 0, rdat, 8'h00);
    step_to(3);

    // Single read on port 1, default timing.
    ad_in_v[0] = 8'h37;
    run_txn(0, 1'b1, 1'b0, 8'h22, 8'h00, n, wa, wd, rl, rdat);
    chki("rd_latency", n, 23);
    chki("rd_addr_strobe", wa, 5);
    chki("rd_strobe_oe_off", rl, 5);
    chki("rd_no_data_wr", wd, 0);
    chk8("rd_rdata", 0, rdat, 8'h37);
    step_to(3);

    // All-ones timing instance.
    run_txn(1, 1'b0, 1'b1, 8'h05, 8'h6C, n, wa, wd, rl, rdat);
    chki("t1_wr_latency", n, 8);
    chki("t1_wr_addr_strobe", wa, 1);
    chki("t1_wr_data_strobe", wd, 1);
    step_to(2);
    ad_in_v[1] = 8'hA5;
    run_txn(1, 1'b1, 1'b0, 8'h06, 8'h00, n, wa, wd, rl, rdat);
    chki("t1_rd_latency", n, 8);
    chki("t1_rd_strobe", rl, 1);
    chk8("t1_rd_rdata", 1, rdat, 8'hA5);
    step_to(3);

    // Reset dropped in the middle of a write's data strobe.
    req0_v[0] = 1'b1; we0_v[0] = 1'b1; addr0_v[0] = 8'h30; wdata0_v[0] = 8'h5A;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (!wr_v[0] && a_d_v[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk1("midrst_reached_d_pw", 0, found, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("midrst_cs", 0, cs_v[0], 1'b1);
    chk1("midrst_rd", 0, rd_v[0], 1'b1);
    chk1("midrst_wr", 0, wr_v[0], 1'b1);
    chk1("midrst_a_d", 0, a_d_v[0], 1'b1);
    chk1("midrst_oe", 0, ad_oe_v[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk1("midrst_no_ack", 0, ack0_v[0], 1'b0);
    end
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (ack0_v[0]) break;
    end
    req0_v[0] = 1'b0;
    chki("post_rst_latency", n, 23);
    step_to(3);

    // Random mixed traffic on both instances, with one asynchronous reset midway.
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      if (c == 2000) begin
        #2;
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c == 2000) rst = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      req0_v[i] = 1'b0;
      req1_v[i] = 1'b0;
    end
    step_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
